hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
- Pipeline hazard controller and matrix-unit scheduler for the five-stage core.
- Drives stall and flush controls for the PC, IF/ID and ID/EX registers, including the `id_ex_flush` input of the ID/EX register.
- Detects load-use hazards and resolves taken branches.
- Sequences multi-cycle matrix instructions by freezing the front end until the matrix unit reports completion or a timeout fires.

Parameters:
- MX_TIMEOUT, 64: maximum cycles in MX_BUSY before a forced abort.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_mx_op  in  1  ID instruction is a matrix instruction.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_br_taken  in  1  branch/jump resolved taken in EX this cycle.
- mx_done  in  1  matrix unit completion, single-cycle pulse.
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  hold the IF/ID register.
- if_id_flush  out  1  zero the IF/ID register.
- id_ex_flush  out  1  load a bubble into ID/EX.
- mx_start  out  1  matrix unit latches its operands from EX this cycle.
- mx_busy  out  1  matrix operation in flight.
- mx_timeout  out  1  one-cycle pulse on timeout abort.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_stall=1.

Behaviour:
- States: IDLE, MX_ISSUE, MX_BUSY. State, timeout counter and stall_cnt are registered. Control outputs are combinational (Mealy) from state and current inputs, so they have zero latency.
- Reset (asynchronous, rst=1):
  - state=IDLE, timeout counter=0, stall_cnt=0.
  - All control outputs forced to 0 while rst=1, regardless of the other inputs.
- Load-use hazard, `lu`:
  - `lu` = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- IDLE:
  - ex_br_taken=1: if_id_flush=1, id_ex_flush=1, no stall. Branch has priority over `lu` and over id_mx_op; stay IDLE.
  - else `lu`=1: pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble); stay IDLE. Next cycle the load has left EX and the hazard clears.
  - else id_mx_op=1: no stall or flush. The matrix instruction advances into EX. Next state MX_ISSUE.
  - else: all control outputs 0.
- MX_ISSUE (matrix instruction is in EX):
  - mx_start=1, mx_busy=1, pc_stall=1, if_id_stall=1.
  - id_ex_flush=0, so the matrix instruction is not destroyed before mx_start.
  - Clear the timeout counter. Next state MX_BUSY.
  - ex_br_taken is ignored in this state.
- MX_BUSY:
  - mx_busy=1, pc_stall=1, if_id_stall=1, id_ex_flush=1 every cycle, so bubbles follow the matrix op.
  - The timeout counter increments each cycle.
  - mx_done=1: release in the same cycle (pc_stall=0, if_id_stall=0, id_ex_flush=0, mx_busy=0) and go to IDLE. The ID instruction advances in that cycle.
  - Counter reaches MX_TIMEOUT-1 without mx_done: mx_timeout=1 for that cycle, stalls released as for mx_done, go to IDLE.
  - mx_done and the timeout in the same cycle: treat as done, mx_timeout=0.
  - ex_br_taken and `lu` are ignored (EX holds bubbles).
- mx_done outside MX_BUSY: ignored.
- stall_cnt:
  - Increments on every clock edge where pc_stall=1.
  - Saturates at all-ones and never wraps.
  - Cleared only by rst.
- Reset mid-operation (MX_ISSUE or MX_BUSY): immediate return to IDLE and all outputs to 0. The matrix unit is reset by the same rst.
- Register index 0 never creates a hazard.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_stall=if_id_stall=id_ex_flush=1 for exactly one cycle; stall_cnt 0->1.
- x0 and unused operand: ex_rd=0 with id_rs1=0, then ex_rd=7 with id_rs2=7 and id_use_rs2=0 -> no stall and no flush in either case.
- Branch priority: ex_br_taken=1 together with a load-use match -> if_id_flush=id_ex_flush=1, pc_stall=0, stall_cnt unchanged.
- Matrix sequence: id_mx_op=1 in IDLE, mx_done pulsed 10 cycles after mx_start ->
  - mx_start high for exactly 1 cycle;
  - pc_stall high for 11 cycles;
  - id_ex_flush=0 in the MX_ISSUE cycle and 1 in the following 10 cycles;
  - state returns to IDLE.
- Timeout with MX_TIMEOUT=8 and no mx_done -> mx_timeout pulses once on the 8th MX_BUSY cycle and the stalls release in the same cycle. A second run with mx_done in that same cycle -> mx_timeout=0.
- Async reset and saturation:
  - Assert rst mid-MX_BUSY, away from a clock edge -> all outputs 0 immediately, stall_cnt=0.
  - With CNT_W=4, hold the stall for 20 cycles -> stall_cnt sticks at 15.

Source files
------------

// File: rtl/hazard_sched.sv
// Pipeline hazard controller and matrix-unit scheduler for the five-stage core.
// Resolves load-use hazards and taken branches, and freezes the front end while
// a multi-cycle matrix instruction runs, until completion or a timeout abort.
// Control outputs are Mealy (state + current inputs) so they act in the same cycle.
module hazard_sched #(
  parameter int MX_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_mx_op,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             mx_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mx_start,
  output logic             mx_busy,
  output logic             mx_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MX_ISSUE = 2'd1,
    MX_BUSY  = 2'd2
  } state_t;

  localparam int                TO_W    = (MX_TIMEOUT > 1) ? $clog2(MX_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(MX_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE  = TO_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_lu;
  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_mx_start;
  logic w_mx_busy;
  logic w_mx_timeout;

  // Load-use hazard: the load in EX writes a register the ID instruction reads; x0 never hazards.
  assign w_lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));

  // Next-state and Mealy control decode; everything is forced low while rst is held.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latch).
    w_state_nxt   = r_state;
    w_pc_stall    = 1'b0;
    w_if_id_stall = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_mx_start    = 1'b0;
    w_mx_busy     = 1'b0;
    w_mx_timeout  = 1'b0;

    case (r_state)
      IDLE: begin
        if (ex_br_taken) begin
          // Taken branch squashes the two younger instructions; wins over everything else.
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (w_lu) begin
          // Hold fetch/decode one cycle and insert a bubble behind the load.
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (id_mx_op) begin
          // Let the matrix op advance into EX untouched; issue it next cycle.
          w_state_nxt = MX_ISSUE;
        end
      end

      MX_ISSUE: begin
        // Matrix op sits in EX: keep ID/EX intact so the unit can latch its operands.
        w_mx_start    = 1'b1;
        w_mx_busy     = 1'b1;
        w_pc_stall    = 1'b1;
        w_if_id_stall = 1'b1;
        w_state_nxt   = MX_BUSY;
      end

      MX_BUSY: begin
        if (mx_done) begin
          // Completion releases the front end in this very cycle.
          w_state_nxt = IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          // Forced abort; release as for completion and flag it for one cycle.
          w_mx_timeout = 1'b1;
          w_state_nxt  = IDLE;
        end else begin
          w_mx_busy     = 1'b1;
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    if (rst) begin
      w_state_nxt   = IDLE;
      w_pc_stall    = 1'b0;
      w_if_id_stall = 1'b0;
      w_if_id_flush = 1'b0;
      w_id_ex_flush = 1'b0;
      w_mx_start    = 1'b0;
      w_mx_busy     = 1'b0;
      w_mx_timeout  = 1'b0;
    end
  end

  // State register and matrix timeout counter (cleared at issue, counts BUSY cycles).
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state  <= IDLE;
      r_to_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == MX_ISSUE) begin
        r_to_cnt <= '0;
      end else if (r_state == MX_BUSY) begin
        r_to_cnt <= r_to_cnt + TO_ONE;
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_pc_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign pc_stall    = w_pc_stall;
  assign if_id_stall = w_if_id_stall;
  assign if_id_flush = w_if_id_flush;
  assign id_ex_flush = w_id_ex_flush;
  assign mx_start    = w_mx_start;
  assign mx_busy     = w_mx_busy;
  assign mx_timeout  = w_mx_timeout;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched. Two instances share stimulus: u_big uses the
// default parameters, u_small uses MX_TIMEOUT=8 / CNT_W=4 for timeout and saturation.
`timescale 1ns/1ps
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, id_mx_op, ex_mem_read, ex_br_taken, mx_done;

  logic        b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_flush;
  logic        b_mx_start, b_mx_busy, b_mx_timeout;
  logic [15:0] b_stall_cnt;
  logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_flush;
  logic        s_mx_start, s_mx_busy, s_mx_timeout;
  logic [3:0]  s_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Control bundles: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, mx_start, mx_busy, mx_timeout}
  logic [6:0] b_ctrl, s_ctrl;
  assign b_ctrl = {b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_flush, b_mx_start, b_mx_busy, b_mx_timeout};
  assign s_ctrl = {s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_flush, s_mx_start, s_mx_busy, s_mx_timeout};

  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_LU     = 7'b1101000;
  localparam logic [6:0] C_BR     = 7'b0011000;
  localparam logic [6:0] C_ISSUE  = 7'b1100110;
  localparam logic [6:0] C_BUSY   = 7'b1101010;
  localparam logic [6:0] C_TMO    = 7'b0000001;

  hazard_sched u_big (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_mx_op(id_mx_op), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .mx_done(mx_done),
    .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .if_id_flush(b_if_id_flush),
    .id_ex_flush(b_id_ex_flush), .mx_start(b_mx_start), .mx_busy(b_mx_busy),
    .mx_timeout(b_mx_timeout), .stall_cnt(b_stall_cnt)
  );

  hazard_sched #(.MX_TIMEOUT(8), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_mx_op(id_mx_op), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .mx_done(mx_done),
    .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .mx_start(s_mx_start), .mx_busy(s_mx_busy),
    .mx_timeout(s_mx_timeout), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_mx_op = 0;
    ex_mem_read = 0; ex_br_taken = 0; mx_done = 0;
  endtask

  // Load in EX writing x5, ID reads x5 through rs1.
  task automatic set_lu();
    ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
  endtask

  initial begin
    // ---- Reset: outputs forced low even with a hazard on the inputs ----
    clear_in();
    rst = 1;
    set_lu();
    ex_br_taken = 1;
    #2;
    check("rst_ctrl_big", b_ctrl, C_NONE);
    check("rst_ctrl_small", s_ctrl, C_NONE);
    check("rst_cnt", b_stall_cnt, 0);
    clear_in();
    @(negedge clk);
    rst = 0;
    tick();

    // ---- Load-use: one stall cycle, then clear ----
    set_lu();
    #2;
    check("lu_ctrl", b_ctrl, C_LU);
    check("lu_cnt_before", b_stall_cnt, 0);
    tick();
    clear_in();
    #2;
    check("lu_cleared", b_ctrl, C_NONE);
    check("lu_cnt_after", b_stall_cnt, 1);
    check("lu_cnt_after_small", s_stall_cnt, 1);
    tick();

    // ---- x0 and unused operand: no hazard ----
    ex_mem_read = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
    #2;
    check("x0_no_hazard", b_ctrl, C_NONE);
    tick();
    clear_in();
    ex_mem_read = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 0;
    #2;
    check("unused_rs2", b_ctrl, C_NONE);
    tick();
    clear_in();

    // ---- Branch beats load-use ----
    set_lu();
    ex_br_taken = 1;
    #2;
    check("br_priority", b_ctrl, C_BR);
    tick();
    clear_in();
    #2;
    check("br_cnt_unchanged", b_stall_cnt, 1);
    tick();

    // ---- Matrix sequence (done on 11th BUSY cycle); small instance times out on its 8th ----
    id_mx_op = 1;
    #2;
    check("mx_accept", b_ctrl, C_NONE);
    tick();
    clear_in();
    ex_br_taken = 1;  // ignored while issuing
    #2;
    check("mx_issue_big", b_ctrl, C_ISSUE);
    check("mx_issue_small", s_ctrl, C_ISSUE);
    tick();
    for (int c = 1; c <= 10; c++) begin
      clear_in();
      if (c == 3) begin
        set_lu();
        ex_br_taken = 1;  // ignored while busy
      end
      #2;
      check($sformatf("mx_busy_big_%0d", c), b_ctrl, C_BUSY);
      if (c < 8)       check($sformatf("mx_busy_small_%0d", c), s_ctrl, C_BUSY);
      else if (c == 8) check("mx_timeout_small", s_ctrl, C_TMO);
      else             check($sformatf("mx_after_tmo_small_%0d", c), s_ctrl, C_NONE);
      tick();
    end
    clear_in();
    mx_done = 1;
    #2;
    check("mx_done_release", b_ctrl, C_NONE);
    check("mx_cnt", b_stall_cnt, 12);
    tick();
    clear_in();
    set_lu();
    #2;
    check("mx_back_idle", b_ctrl, C_LU);
    tick();
    clear_in();
    mx_done = 1;  // stray pulse in IDLE
    #2;
    check("done_in_idle", b_ctrl, C_NONE);
    check("mx_cnt_after_lu", b_stall_cnt, 13);
    tick();
    clear_in();

    // ---- Done and timeout collide on the small instance's 8th BUSY cycle ----
    id_mx_op = 1;
    tick();
    clear_in();
    #2;
    check("tmo2_issue_small", s_ctrl, C_ISSUE);
    tick();
    for (int c = 1; c <= 8; c++) begin
      clear_in();
      if (c == 8) mx_done = 1;
      #2;
      if (c < 8) begin
        check($sformatf("tmo2_busy_small_%0d", c), s_ctrl, C_BUSY);
      end else begin
        check("tmo2_done_wins_small", s_ctrl, C_NONE);
        check("tmo2_done_big", b_ctrl, C_NONE);
      end
      tick();
    end
    clear_in();

    // ---- Async reset in the middle of MX_BUSY ----
    id_mx_op = 1;
    tick();
    clear_in();
    tick();
    tick();
    #2;
    check("rst_mid_busy_pre", b_ctrl, C_BUSY);
    rst = 1;
    #1;
    check("rst_mid_busy_ctrl", b_ctrl, C_NONE);
    check("rst_mid_busy_cnt", b_stall_cnt, 0);
    check("rst_mid_busy_cnt_small", s_stall_cnt, 0);
    @(negedge clk);
    rst = 0;
    tick();
    #2;
    check("post_rst_idle", b_ctrl, C_NONE);

    // ---- Saturation: hold load-use for 20 cycles ----
    set_lu();
    for (int i = 0; i < 20; i++) begin
      #2;
      if (i == 0)  check("sat_stall", b_ctrl, C_LU);
      if (i == 15) check("sat_small_15", s_stall_cnt, 15);
      if (i == 19) check("sat_small_hold", s_stall_cnt, 15);
      tick();
    end
    clear_in();
    #2;
    check("sat_small_final", s_stall_cnt, 15);
    check("sat_big_final", b_stall_cnt, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
